// File: rtl/tetris_renderer.sv
// tetris_renderer: turns the visible pixel stream into board/piece colours.
// Three stages: cell query, piece overlay + colour pick, RGB lookup.
module tetris_renderer #(
  parameter int unsigned ORIGIN_X   = 240,
  parameter int unsigned ORIGIN_Y   = 48,
  parameter int unsigned CELL_LOG2  = 4,
  parameter int unsigned BOARD_W    = 10,
  parameter int unsigned BOARD_H    = 12,
  parameter int unsigned BORDER_PX  = 4,
  parameter logic [23:0] BORDER_RGB = 24'hC0C0C0,
  parameter logic [23:0] GRID_RGB   = 24'h202020
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] vis_x,
  input  logic [12:0] vis_y,
  input  logic [2:0]  hve,
  output logic [4:0]  q_x,
  output logic [4:0]  q_y,
  input  logic [3:0]  q_color,
  input  logic [2:0]  cur_shape,
  input  logic [1:0]  cur_rot,
  input  logic [4:0]  cur_x,
  input  logic [5:0]  cur_y,
  input  logic [3:0]  cur_color,
  output logic [23:0] rgb,
  output logic [2:0]  hve_o
);

  localparam logic [12:0] OX = 13'(ORIGIN_X);
  localparam logic [12:0] OY = 13'(ORIGIN_Y);
  localparam logic [12:0] BX0 = 13'(ORIGIN_X - BORDER_PX);
  localparam logic [12:0] BY0 = 13'(ORIGIN_Y - BORDER_PX);
  localparam logic [12:0] W_PX = 13'(BOARD_W << CELL_LOG2);
  localparam logic [12:0] H_PX = 13'(BOARD_H << CELL_LOG2);
  localparam logic [12:0] BW_PX =
    13'((BOARD_W << CELL_LOG2) + 2 * BORDER_PX);
  localparam logic [12:0] BH_PX =
    13'((BOARD_H << CELL_LOG2) + 2 * BORDER_PX);
  localparam logic [12:0] SUB_MAX = 13'((1 << CELL_LOG2) - 1);

  // rotation-0 piece masks, bit = row*4 + col; shape 7 aliases L
  function automatic logic [15:0] shape_mask(input logic [2:0] s);
    logic [15:0] m;
    case (s)
      3'd0:    m = 16'h00F0;
      3'd1:    m = 16'h0066;
      3'd2:    m = 16'h0027;
      3'd3:    m = 16'h0036;
      3'd4:    m = 16'h0063;
      3'd5:    m = 16'h0071;
      default: m = 16'h0074;
    endcase
    return m;
  endfunction

  function automatic logic [23:0] pal(input logic [3:0] i);
    logic [23:0] c;
    case (i)
      4'd0:    c = 24'h000000;
      4'd1:    c = 24'h00FFFF;
      4'd2:    c = 24'hFFFF00;
      4'd3:    c = 24'hA000F0;
      4'd4:    c = 24'h00F000;
      4'd5:    c = 24'hF00000;
      4'd6:    c = 24'h0000F0;
      4'd7:    c = 24'hF0A000;
      default: c = 24'h808080;
    endcase
    return c;
  endfunction

  logic [12:0] rx;
  logic [12:0] ry;
  logic [12:0] bx;
  logic [12:0] by;
  logic        in_board;
  logic        in_border;
  logic        grid;
  logic [4:0]  cell_x;
  logic [4:0]  cell_y;

  // board-relative coordinates; unsigned wrap makes left/top misses huge
  assign rx = vis_x - OX;
  assign ry = vis_y - OY;
  assign bx = vis_x - BX0;
  assign by = vis_y - BY0;
  assign in_board = (rx < W_PX) && (ry < H_PX);
  assign in_border = !in_board && (bx < BW_PX) && (by < BH_PX);
  assign grid = ((rx & SUB_MAX) == SUB_MAX) ||
                ((ry & SUB_MAX) == SUB_MAX);
  assign cell_x = 5'(rx >> CELL_LOG2);
  assign cell_y = 5'(ry >> CELL_LOG2);

  logic        in_board_1;
  logic        in_border_1;
  logic        grid_1;
  logic [2:0]  hve_1;

  // stage 1: issue the board query and carry pixel class forward
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_x         <= 5'd31;
      q_y         <= 5'd31;
      in_board_1  <= 1'b0;
      in_border_1 <= 1'b0;
      grid_1      <= 1'b0;
      hve_1       <= '0;
    end else begin
      q_x         <= in_board ? cell_x : 5'd31;
      q_y         <= in_board ? cell_y : 5'd31;
      in_board_1  <= in_board;
      in_border_1 <= in_border;
      grid_1      <= grid;
      hve_1       <= hve;
    end
  end

  logic [2:0] snap_shape;
  logic [1:0] snap_rot;
  logic [4:0] snap_x;
  logic [5:0] snap_y;
  logic [3:0] snap_color;

  // piece snapshot refreshed only during vsync so a frame never tears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_shape <= 3'd0;
      snap_rot   <= 2'd0;
      snap_x     <= 5'd3;
      snap_y     <= 6'h3D;
      snap_color <= 4'd0;
    end else if (hve[1]) begin
      snap_shape <= cur_shape;
      snap_rot   <= cur_rot;
      snap_x     <= cur_x;
      snap_y     <= cur_y;
      snap_color <= cur_color;
    end
  end

  logic [6:0]  pr;
  logic [6:0]  pc;
  logic [1:0]  sr;
  logic [1:0]  sc;
  logic [15:0] mask;
  logic        hit;
  logic [3:0]  idx;

  // overlay: map the cell into the piece box, undo rotation, test mask
  always_comb begin
    pr   = {2'b00, q_y} - {snap_y[5], snap_y};
    pc   = {2'b00, q_x} - {2'b00, snap_x};
    sr   = pr[1:0];
    sc   = pc[1:0];
    mask = shape_mask(snap_shape);
    case (snap_rot)
      2'd0: begin sr = pr[1:0];  sc = pc[1:0];  end
      2'd1: begin sr = ~pc[1:0]; sc = pr[1:0];  end
      2'd2: begin sr = ~pr[1:0]; sc = ~pc[1:0]; end
      default: begin sr = pc[1:0]; sc = ~pr[1:0]; end
    endcase
    hit = (snap_color != 4'd0) && (pr[6:2] == 5'd0) &&
          (pc[6:2] == 5'd0) && mask[{sr, sc}];
    idx = hit ? snap_color : q_color;
  end

  logic [3:0] idx_2;
  logic       in_board_2;
  logic       in_border_2;
  logic       grid_2;
  logic [2:0] hve_2;

  // stage 2: capture the resolved colour index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_2       <= '0;
      in_board_2  <= 1'b0;
      in_border_2 <= 1'b0;
      grid_2      <= 1'b0;
      hve_2       <= '0;
    end else begin
      idx_2       <= idx;
      in_board_2  <= in_board_1;
      in_border_2 <= in_border_1;
      grid_2      <= grid_1;
      hve_2       <= hve_1;
    end
  end

  // stage 3: priority colour select into the output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb   <= '0;
      hve_o <= '0;
    end else begin
      hve_o <= hve_2;
      if (!hve_2[2])
        rgb <= '0;
      else if (in_border_2)
        rgb <= BORDER_RGB;
      else if (!in_board_2)
        rgb <= '0;
      else if (idx_2 != 4'd0)
        rgb <= pal(idx_2);
      else if (grid_2)
        rgb <= GRID_RGB;
      else
        rgb <= '0;
    end
  end

endmodule

// File: tb/tb_tetris_renderer.sv
// tb_tetris_renderer: random pixel stream against a frame-level model.
// Board stub answers q_x/q_y combinationally from a bench array.
module tb_tetris_renderer;

  localparam int OX = 240;
  localparam int OY = 48;
  localparam int CS = 16;
  localparam int BW = 10;
  localparam int BH = 12;
  localparam int BP = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] vis_x;
  logic [12:0] vis_y;
  logic [2:0]  hve;
  logic [4:0]  q_x;
  logic [4:0]  q_y;
  logic [3:0]  q_color;
  logic [2:0]  cur_shape;
  logic [1:0]  cur_rot;
  logic [4:0]  cur_x;
  logic [5:0]  cur_y;
  logic [3:0]  cur_color;
  logic [23:0] rgb;
  logic [2:0]  hve_o;

  int board [BH][BW];
  int s_shape, s_rot, s_x, s_y, s_color;
  int n_chk = 0;
  int n_fail = 0;
  logic [23:0] exp_rgb [$];
  logic [2:0]  exp_hve [$];
  int unsigned base_mask [7] =
    '{'h00F0, 'h0066, 'h0027, 'h0036, 'h0063, 'h0071, 'h0074};

  always #5 clk = ~clk;

  always_comb begin
    q_color = 4'd0;
    if (q_x < 5'(BW) && q_y < 5'(BH))
      q_color = 4'(board[q_y][q_x]);
  end

  tetris_renderer dut (
    .clk(clk), .reset_n(reset_n),
    .vis_x(vis_x), .vis_y(vis_y), .hve(hve),
    .q_x(q_x), .q_y(q_y), .q_color(q_color),
    .cur_shape(cur_shape), .cur_rot(cur_rot),
    .cur_x(cur_x), .cur_y(cur_y), .cur_color(cur_color),
    .rgb(rgb), .hve_o(hve_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pal(int i);
    case (i)
      1: return 24'h00FFFF;
      2: return 24'hFFFF00;
      3: return 24'hA000F0;
      4: return 24'h00F000;
      5: return 24'hF00000;
      6: return 24'h0000F0;
      7: return 24'hF0A000;
      default: return (i >= 8) ? 24'h808080 : 24'h000000;
    endcase
  endfunction

  function automatic bit piece_at(int cx, int cy);
    bit m [4][4];
    bit t [4][4];
    int sh;
    if (s_color == 0) return 1'b0;
    sh = (s_shape > 6) ? 6 : s_shape;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = ((base_mask[sh] >> (r * 4 + c)) & 1) != 0;
    for (int k = 0; k < s_rot; k++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = m[3 - c][r];
      m = t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[r][c] && cy == s_y + r && cx == s_x + c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [23:0] model_rgb(int x, int y, logic [2:0] h);
    bit ib, bd;
    int cx, cy, idx;
    if (!h[2]) return 24'h0;
    ib = x >= OX && x < OX + BW * CS && y >= OY && y < OY + BH * CS;
    bd = !ib && x >= OX - BP && x < OX + BW * CS + BP &&
         y >= OY - BP && y < OY + BH * CS + BP;
    if (bd) return 24'hC0C0C0;
    if (!ib) return 24'h0;
    cx = (x - OX) / CS;
    cy = (y - OY) / CS;
    idx = piece_at(cx, cy) ? s_color : board[cy][cx];
    if (idx != 0) return pal(idx);
    if ((x - OX) % CS == CS - 1 || (y - OY) % CS == CS - 1)
      return 24'h202020;
    return 24'h0;
  endfunction

  task automatic px(input int x, input int y, input logic [2:0] h);
    int eqx, eqy;
    vis_x = 13'(x);
    vis_y = 13'(y);
    hve = h;
    if (h[1]) begin
      s_shape = int'(cur_shape);
      s_rot = int'(cur_rot);
      s_x = int'(cur_x);
      s_y = int'($signed(cur_y));
      s_color = int'(cur_color);
    end
    exp_rgb.push_back(model_rgb(x, y, h));
    exp_hve.push_back(h);
    if (x >= OX && x < OX + BW * CS && y >= OY && y < OY + BH * CS) begin
      eqx = (x - OX) / CS;
      eqy = (y - OY) / CS;
    end else begin
      eqx = 31;
      eqy = 31;
    end
    @(posedge clk);
    #1;
    chk("q_x", 32'(q_x), 32'(eqx));
    chk("q_y", 32'(q_y), 32'(eqy));
    if (exp_rgb.size() == 3) begin
      chk("rgb", 32'(rgb), 32'(exp_rgb.pop_front()));
      chk("hve_o", 32'(hve_o), 32'(exp_hve.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(0, 0, 3'b000);
  endtask

  task automatic snap_reset();
    s_shape = 0; s_rot = 0; s_x = 3; s_y = -3; s_color = 0;
  endtask

  task automatic load_piece(input int sh, input int ro, input int x,
                            input int y, input int co);
    cur_shape = 3'(sh);
    cur_rot = 2'(ro);
    cur_x = 5'(x);
    cur_y = 6'(y);
    cur_color = 4'(co);
  endtask

  initial begin
    int x, y;
    logic de, hs;
    reset_n = 1'b0;
    vis_x = '0; vis_y = '0; hve = '0;
    load_piece(0, 0, 0, 0, 0);
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) board[r][c] = 0;
    snap_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hve", 32'(hve_o), 32'h0);
    chk("rst_qx", 32'(q_x), 32'd31);
    chk("rst_qy", 32'(q_y), 32'd31);
    @(negedge clk);
    reset_n = 1'b1;

    px(0, 0, 3'b100);
    idle(2);
    chk("origin_rgb", 32'(rgb), 32'h0);
    chk("origin_hve", 32'(hve_o), 32'h4);

    board[5][2] = 4;
    px(OX + 35, OY + 83, 3'b100);
    chk("cell_qx", 32'(q_x), 32'd2);
    chk("cell_qy", 32'(q_y), 32'd5);
    idle(2);
    chk("cell_rgb", 32'(rgb), 32'h00F000);
    board[5][2] = 0;

    px(OX + 15, OY + 3, 3'b100);
    idle(2);
    chk("grid_rgb", 32'(rgb), 32'h202020);
    px(OX + 3, OY + 3, 3'b100);
    idle(2);
    chk("empty_rgb", 32'(rgb), 32'h0);

    load_piece(2, 0, 3, -1, 5);
    px(0, 0, 3'b010);
    board[0][3] = 2;
    px(OX + 4 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("t0_c4", 32'(rgb), 32'hF00000);
    px(OX + 3 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("t0_c3", 32'(rgb), 32'hFFFF00);

    cur_rot = 2'd1;
    px(0, 0, 3'b010);
    px(OX + 3 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("t1_c3", 32'(rgb), 32'hFFFF00);
    px(OX + 4 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("t1_c4", 32'(rgb), 32'h0);
    px(OX + 5 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("t1_c5", 32'(rgb), 32'hF00000);

    load_piece(1, 0, 0, 0, 3);
    px(OX + 5 * CS + 5, OY + 5, 3'b101);
    idle(2);
    chk("tear_old", 32'(rgb), 32'hF00000);
    px(0, 0, 3'b010);
    px(OX + 1 * CS + 5, OY + CS + 5, 3'b100);
    idle(2);
    chk("vs_new", 32'(rgb), 32'hA000F0);
    px(OX + 5 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("vs_gone", 32'(rgb), 32'h0);

    px(OX - 2, OY + 10, 3'b100);
    idle(2);
    chk("border_rgb", 32'(rgb), 32'hC0C0C0);
    px(OX - 2, OY + 10, 3'b000);
    idle(2);
    chk("border_de0", 32'(rgb), 32'h0);

    board[3][3] = 7;
    px(OX + 3 * CS + 5, OY + 3 * CS + 5, 3'b100);
    idle(2);
    chk("pre_rst", 32'(rgb), 32'hF0A000);
    px(OX + 3 * CS + 5, OY + 3 * CS + 5, 3'b100);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_hve", 32'(hve_o), 32'h0);
    chk("mid_rst_qx", 32'(q_x), 32'd31);
    exp_rgb.delete();
    exp_hve.delete();
    snap_reset();
    @(negedge clk);
    reset_n = 1'b1;
    board[3][3] = 0;
    board[0][3] = 0;
    board[0][4] = 6;
    px(OX + 4 * CS + 5, OY + 5, 3'b100);
    idle(2);
    chk("post_rst", 32'(rgb), 32'h0000F0);

    for (int f = 0; f < 20; f++) begin
      idle(2);
      for (int r = 0; r < BH; r++)
        for (int c = 0; c < BW; c++)
          board[r][c] = ($urandom_range(0, 9) < 3) ?
                        int'($urandom_range(1, 15)) : 0;
      load_piece(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 15)) - 3,
                 int'($urandom_range(0, 15)));
      px(0, 0, 3'b010);
      cur_color = 4'($urandom_range(0, 15));
      cur_rot = 2'($urandom_range(0, 3));
      for (int p = 0; p < 150; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          x = OX + (s_x + int'($urandom_range(0, 3))) * CS +
              int'($urandom_range(0, 15));
          y = OY + (s_y + int'($urandom_range(0, 3))) * CS +
              int'($urandom_range(0, 15));
        end else begin
          x = int'($urandom_range(OX - 8, OX + BW * CS + 8));
          y = int'($urandom_range(OY - 8, OY + BH * CS + 8));
        end
        de = ($urandom_range(0, 7) != 0);
        hs = 1'($urandom_range(0, 1));
        px(x, y, {de, 1'b0, hs});
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
